// File: rtl/pipe_stage_queue.sv
// -----------------------------------------------------------------------------
// pipe_stage_queue
//   Elastic inter-stage pipeline register. Holds up to DEPTH payloads in a
//   circular buffer with a valid/ready handshake on each side, so an upstream
//   stage can keep issuing while the downstream stage stalls. A flush discards
//   every held entry plus any same-cycle push. Two saturating counters report
//   downstream back-pressure cycles and flush cycles.
//
// Parameters
//   DATA_W  payload width
//   DEPTH   number of entries (>=1, any value, not only powers of two)
//   CNT_W   width of stall_cnt / flush_cnt
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high reset (wins over flush)
//   in_valid   upstream offers in_data
//   in_ready   a push is accepted this cycle (registered state only)
//   in_data    payload to push
//   flush      drop all held and incoming entries
//   out_valid  out_data holds the oldest entry
//   out_ready  downstream consumes the oldest entry
//   out_data   oldest entry, zero when out_valid is low
//   occupancy  number of entries held
//   stall_cnt  cycles with out_valid=1, out_ready=0 and no flush (saturating)
//   flush_cnt  cycles with flush=1 (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Explicit wrap so a non-power-of-two DEPTH never indexes past the end.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [OCC_W-1:0] occ_q,       occ_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic push;
    logic pop;

    // Handshake outputs come from registered state only.
    assign in_ready  = (occ_q != OCC_FULL);
    assign out_valid = (occ_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign occupancy = occ_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Flush masks both handshakes so neither pointer moves on its own.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        occ_d       = occ_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            occ_d       = '0;
            rd_ptr_d    = wr_ptr_q;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
            if (out_valid && !out_ready) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_queue.sv
module tb_pipe_stage_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=2, CNT_W=4
    logic        a_rst, a_iv, a_ir, a_fl, a_ov, a_or;
    logic [31:0] a_din, a_dout;
    logic [1:0]  a_occ;
    logic [3:0]  a_stall, a_flcnt;

    // Instance B: DEPTH=3, CNT_W=16
    logic        b_rst, b_iv, b_ir, b_fl, b_ov, b_or;
    logic [31:0] b_din, b_dout;
    logic [2:0]  b_occ;
    logic [15:0] b_stall, b_flcnt;

    pipe_stage_queue #(.DATA_W(32), .DEPTH(2), .CNT_W(4)) dut_a (
        .clk(clk), .reset(a_rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_din),
        .flush(a_fl), .out_valid(a_ov), .out_ready(a_or), .out_data(a_dout),
        .occupancy(a_occ), .stall_cnt(a_stall), .flush_cnt(a_flcnt)
    );

    pipe_stage_queue #(.DATA_W(32), .DEPTH(3), .CNT_W(16)) dut_b (
        .clk(clk), .reset(b_rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_din),
        .flush(b_fl), .out_valid(b_ov), .out_ready(b_or), .out_data(b_dout),
        .occupancy(b_occ), .stall_cnt(b_stall), .flush_cnt(b_flcnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: a queue of payloads plus two saturating counters.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int sa, fa, sb, fb;

    task automatic model_update();
        int occ;
        bit pop, push;
        if (a_rst) begin
            qa.delete(); sa = 0; fa = 0;
        end else if (a_fl) begin
            qa.delete(); if (fa != 15) fa++;
        end else begin
            occ  = qa.size();
            pop  = (occ != 0) && a_or;
            push = a_iv && (occ != 2);
            if (occ != 0 && !a_or && sa != 15) sa++;
            if (pop)  void'(qa.pop_front());
            if (push) qa.push_back(a_din);
        end
        if (b_rst) begin
            qb.delete(); sb = 0; fb = 0;
        end else if (b_fl) begin
            qb.delete(); if (fb != 65535) fb++;
        end else begin
            occ  = qb.size();
            pop  = (occ != 0) && b_or;
            push = b_iv && (occ != 3);
            if (occ != 0 && !b_or && sb != 65535) sb++;
            if (pop)  void'(qb.pop_front());
            if (push) qb.push_back(b_din);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic a_drive(input logic r, input logic iv, input logic [31:0] d,
                           input logic fl, input logic orr);
        a_rst = r; a_iv = iv; a_din = d; a_fl = fl; a_or = orr;
    endtask

    task automatic b_drive(input logic r, input logic iv, input logic [31:0] d,
                           input logic fl, input logic orr);
        b_rst = r; b_iv = iv; b_din = d; b_fl = fl; b_or = orr;
    endtask

    typedef struct {
        logic        rst, iv, fl, orr;
        logic [31:0] din;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
        logic        e_ir;
        logic [3:0]  e_stall, e_flush;
    } vec_t;

    function automatic vec_t mk(logic rst, logic iv, logic [31:0] din, logic fl, logic orr,
                                logic e_ov, logic [31:0] e_od, logic [1:0] e_occ,
                                logic e_ir, logic [3:0] e_stall, logic [3:0] e_flush);
        vec_t v;
        v.rst = rst; v.iv = iv; v.din = din; v.fl = fl; v.orr = orr;
        v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_ir = e_ir;
        v.e_stall = e_stall; v.e_flush = e_flush;
        return v;
    endfunction

    localparam logic [31:0] DA = 32'h1234_0001;
    localparam logic [31:0] DB = 32'h1234_0002;
    localparam logic [31:0] DC = 32'h1234_0003;
    localparam logic [31:0] DD = 32'hABCD_000D;
    localparam logic [31:0] DE = 32'hABCD_000E;
    localparam logic [31:0] DF = 32'hABCD_000F;
    localparam logic [31:0] DG = 32'h5555_AAAA;

    vec_t tv[14];

    initial begin
        logic [31:0] sdat [10];

        // Expected values describe the outputs just after the edge that applies each row.
        //           rst iv din fl or | ov  od  occ ir stall flush
        tv[0]  = mk(1, 0, 0,  0, 0,   0, 0,  0, 1, 0, 0);   // reset
        tv[1]  = mk(0, 1, DA, 0, 1,   1, DA, 1, 1, 0, 0);   // push A, visible next cycle
        tv[2]  = mk(0, 0, 0,  0, 1,   0, 0,  0, 1, 0, 0);   // A consumed
        tv[3]  = mk(0, 1, DA, 0, 0,   1, DA, 1, 1, 0, 0);   // push A, downstream stalled
        tv[4]  = mk(0, 1, DB, 0, 0,   1, DA, 2, 0, 1, 0);   // push B -> full
        tv[5]  = mk(0, 1, DC, 0, 0,   1, DA, 2, 0, 2, 0);   // push C ignored
        tv[6]  = mk(0, 0, 0,  0, 1,   1, DB, 1, 1, 2, 0);   // pop A
        tv[7]  = mk(0, 0, 0,  0, 1,   0, 0,  0, 1, 2, 0);   // pop B
        tv[8]  = mk(0, 1, DD, 0, 0,   1, DD, 1, 1, 2, 0);
        tv[9]  = mk(0, 1, DE, 0, 0,   1, DD, 2, 0, 3, 0);   // full again
        tv[10] = mk(0, 1, DF, 1, 1,   0, 0,  0, 1, 3, 1);   // flush + push + ready
        tv[11] = mk(0, 0, 0,  0, 1,   0, 0,  0, 1, 3, 1);   // nothing reappears
        tv[12] = mk(0, 1, DG, 0, 1,   1, DG, 1, 1, 3, 1);   // queue usable after flush
        tv[13] = mk(0, 0, 0,  0, 1,   0, 0,  0, 1, 3, 1);

        a_drive(1, 0, 0, 0, 0);
        b_drive(1, 0, 0, 0, 0);
        cycle();
        b_drive(0, 0, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            a_drive(tv[i].rst, tv[i].iv, tv[i].din, tv[i].fl, tv[i].orr);
            cycle();
            chk($sformatf("tv%0d out_valid", i), 64'(a_ov),    64'(tv[i].e_ov));
            chk($sformatf("tv%0d out_data", i),  64'(a_dout),  64'(tv[i].e_od));
            chk($sformatf("tv%0d occupancy", i), 64'(a_occ),   64'(tv[i].e_occ));
            chk($sformatf("tv%0d in_ready", i),  64'(a_ir),    64'(tv[i].e_ir));
            chk($sformatf("tv%0d stall_cnt", i), 64'(a_stall), 64'(tv[i].e_stall));
            chk($sformatf("tv%0d flush_cnt", i), 64'(a_flcnt), 64'(tv[i].e_flush));
        end

        // Stall counter saturation at CNT_W=4, then reset mid-transfer.
        a_drive(1, 0, 0, 0, 0);
        cycle();
        a_drive(0, 1, DA, 0, 0);
        cycle();
        chk("sat push occupancy", 64'(a_occ), 64'd1);
        a_drive(0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            chk($sformatf("sat stall k=%0d", k), 64'(a_stall), 64'((k > 15) ? 15 : k));
        end
        chk("sat out_data held", 64'(a_dout), 64'(DA));
        a_drive(1, 1, DB, 0, 0);
        cycle();
        chk("rst out_valid", 64'(a_ov),    64'd0);
        chk("rst out_data",  64'(a_dout),  64'd0);
        chk("rst occupancy", 64'(a_occ),   64'd0);
        chk("rst in_ready",  64'(a_ir),    64'd1);
        chk("rst stall_cnt", 64'(a_stall), 64'd0);
        chk("rst flush_cnt", 64'(a_flcnt), 64'd0);
        a_drive(0, 0, 0, 0, 0);

        // DEPTH=3 streaming across pointer wrap.
        for (int i = 0; i < 10; i++) sdat[i] = 32'hC0DE_0000 + 32'(i * 7 + 1);
        b_drive(1, 0, 0, 0, 0);
        cycle();
        for (int i = 0; i < 10; i++) begin
            b_drive(0, 1, sdat[i], 0, 1);
            cycle();
            chk($sformatf("stream%0d occupancy", i), 64'(b_occ),  64'd1);
            chk($sformatf("stream%0d out_data", i),  64'(b_dout), 64'(sdat[i]));
        end
        b_drive(0, 0, 0, 0, 1);
        cycle();
        chk("stream drain occupancy", 64'(b_occ), 64'd0);
        chk("stream drain out_valid", 64'(b_ov),  64'd0);

        // Randomised traffic on both instances against the queue model.
        a_drive(1, 0, 0, 0, 0);
        b_drive(1, 0, 0, 0, 0);
        cycle();
        for (int n = 0; n < 600; n++) begin
            a_drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
            b_drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
            cycle();
            chk("rndA out_valid", 64'(a_ov),    64'(qa.size() != 0));
            chk("rndA out_data",  64'(a_dout),  64'((qa.size() != 0) ? qa[0] : 32'd0));
            chk("rndA occupancy", 64'(a_occ),   64'(qa.size()));
            chk("rndA in_ready",  64'(a_ir),    64'(qa.size() != 2));
            chk("rndA stall_cnt", 64'(a_stall), 64'(sa));
            chk("rndA flush_cnt", 64'(a_flcnt), 64'(fa));
            chk("rndB out_valid", 64'(b_ov),    64'(qb.size() != 0));
            chk("rndB out_data",  64'(b_dout),  64'((qb.size() != 0) ? qb[0] : 32'd0));
            chk("rndB occupancy", 64'(b_occ),   64'(qb.size()));
            chk("rndB in_ready",  64'(b_ir),    64'(qb.size() != 3));
            chk("rndB stall_cnt", 64'(b_stall), 64'(sb));
            chk("rndB flush_cnt", 64'(b_flcnt), 64'(fb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
